// File: rtl/imem_loader.sv
// Boot loader: assembles a framed little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until a valid frame lands.
module imem_loader #(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              ena,
    output logic [3:0]        wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   idx_q;
    logic [1:0]        byte_cnt_q;
    logic [7:0]        csum_q;
    logic [31:0]       word_q;

    logic              accept;
    logic [15:0]       len_n;
    logic [ADDR_W:0]   idx_inc;

    assign accept  = rx_valid && rx_ready;
    assign len_n   = {rx_data, len_q[7:0]};
    assign idx_inc = idx_q + (ADDR_W + 1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_LEN_LO;
            S_LEN_LO: if (accept) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_n == 16'd0 || 32'(len_n) > 32'(MAX_WORDS)) state_d = S_ERR;
                    else                                                state_d = S_DATA;
                end
            end
            S_DATA:   if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
            // index is one bit wider than addra so N == MAX_WORDS terminates cleanly
            S_WRITE:  state_d = (32'(idx_inc) == 32'(len_q)) ? S_CSUM : S_DATA;
            S_CSUM:   if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:    if (reload) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            word_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    idx_q      <= '0;
                    byte_cnt_q <= '0;
                    csum_q     <= '0;
                    word_q     <= '0;
                end
                S_LEN_LO: if (accept) len_q[7:0]  <= rx_data;
                S_LEN_HI: if (accept) len_q[15:8] <= rx_data;
                S_DATA: begin
                    if (accept) begin
                        word_q     <= {rx_data, word_q[31:8]};
                        csum_q     <= csum_q ^ rx_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                S_WRITE: idx_q <= idx_inc;
                default: ;
            endcase
        end
    end

    // All outputs decode from the state register only; nothing combinational from rx_*
    always_comb begin
        rx_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
        ena       = (state_q == S_WRITE);
        wea       = ena ? 4'hF : 4'h0;
        addra     = ena ? idx_q[ADDR_W-1:0] : '0;
        dina      = ena ? word_q : '0;
        cpu_reset = (state_q != S_DONE);
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum, illegal length, gaps, reset, reload.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic        rx_ready, ena, cpu_reset, done, error;
    logic [3:0]  wea;
    logic [13:0] addra;
    logic [31:0] dina;

    logic        rx_ready2, ena2, cpu_reset2, done2, error2;
    logic [3:0]  wea2;
    logic [3:0]  addra2;
    logic [31:0] dina2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_acc = 0;
    int ready_in_write = 0;

    logic [7:0]  frame[$];
    logic [13:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_wea[$];

    imem_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .reload(reload), .ena(ena), .wea(wea),
        .addra(addra), .dina(dina), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    imem_loader #(.ADDR_W(4)) dut_small (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready2), .reload(reload), .ena(ena2), .wea(wea2),
        .addra(addra2), .dina(dina2), .cpu_reset(cpu_reset2), .done(done2), .error(error2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ena) begin
            wr_addr.push_back(addra);
            wr_data.push_back(dina);
            wr_wea.push_back(wea);
            if (rx_ready) ready_in_write++;
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_wea.delete();
        ready_in_write = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Entered and left at a negedge; rx_valid stays high so the next byte can be back-to-back.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 20; k++) begin
            if (rx_ready) begin
                acc_cyc = cyc;
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout byte=%02h not accepted within 20 cycles", b);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], gaps ? int'($urandom_range(0, 2)) : 0);
            if (i == 0) first_acc = acc_cyc;
        end
        rx_valid = 1'b0;
    endtask

    task automatic load_nominal();
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    endtask

    task automatic check_nominal_writes(input string tag);
        checks++;
        if (wr_addr.size() !== 2) begin
            failures++;
            $display("FAIL %s_write_count got=%0d exp=2", tag, wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'h00500093 || wr_wea[0] !== 4'hF) begin
                failures++;
                $display("FAIL %s_write0 got addr=%0d data=%08h wea=%h exp addr=0 data=00500093 wea=f",
                         tag, wr_addr[0], wr_data[0], wr_wea[0]);
            end
            checks++;
            if (wr_addr[1] !== 14'd1 || wr_data[1] !== 32'h00A00113 || wr_wea[1] !== 4'hF) begin
                failures++;
                $display("FAIL %s_write1 got addr=%0d data=%08h wea=%h exp addr=1 data=00a00113 wea=f",
                         tag, wr_addr[1], wr_data[1], wr_wea[1]);
            end
        end
        checks++;
        if (ready_in_write !== 0) begin
            failures++;
            $display("FAIL %s_ready_in_write got=%0d exp=0", tag, ready_in_write);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rx_ready, ena, wea, addra, dina, cpu_reset, done, error} !==
            {1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got rdy=%b ena=%b wea=%h addr=%0d din=%08h cpu_rst=%b done=%b err=%b exp 0 0 0 0 0 1 0 0",
                     rx_ready, ena, wea, addra, dina, cpu_reset, done, error);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got=%b exp=0", rx_ready);
        end
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_one_cycle got=%b exp=1", rx_ready);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        clear_log();
        load_nominal();
        send_frame(0);
        check_nominal_writes("nominal");
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL nominal_status got done=%b cpu_rst=%b err=%b exp 1 0 0", done, cpu_reset, error);
        end
        // 4N+3+N cycles back-to-back: first accept to csum accept spans 12 edges for N=2
        checks++;
        if (acc_cyc - first_acc !== 12) begin
            failures++;
            $display("FAIL throughput got=%0d exp=12", acc_cyc - first_acc);
        end
    endtask

    task automatic test_bad_csum();
        int rdy_seen = 0;
        do_reset();
        clear_log();
        load_nominal();
        frame[10] = 8'h70;
        send_frame(0);
        check_nominal_writes("badcsum");
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL badcsum_status got err=%b done=%b cpu_rst=%b exp 1 0 1", error, done, cpu_reset);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            if (rx_ready) rdy_seen++;
        end
        rx_valid = 1'b0;
        checks++;
        if (rdy_seen !== 0 || error !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got ready_cycles=%0d err=%b exp 0 1", rdy_seen, error);
        end
    endtask

    task automatic test_illegal_len();
        do_reset();
        clear_log();
        frame = '{8'h00, 8'h00};
        send_frame(0);
        checks++;
        if (error !== 1'b1 || wr_addr.size() !== 0 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_len got err=%b writes=%0d rdy=%b exp 1 0 0", error, wr_addr.size(), rx_ready);
        end
        do_reset();
        frame = '{8'h11, 8'h00};
        send_frame(0);
        checks++;
        if (error2 !== 1'b1 || done2 !== 1'b0) begin
            failures++;
            $display("FAIL len17_small got err=%b done=%b exp 1 0", error2, done2);
        end
        checks++;
        if (error !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL len17_large got err=%b rdy=%b exp 0 1", error, rx_ready);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        clear_log();
        load_nominal();
        send_frame(1);
        check_nominal_writes("gaps");
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL gaps_status got done=%b err=%b exp 1 0", done, error);
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        clear_log();
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50};
        send_frame(0);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL midload_ready got=%b exp=1", rx_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rx_ready, ena, wea, addra, dina, cpu_reset, done, error} !==
            {1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midload_async_reset got rdy=%b ena=%b cpu_rst=%b done=%b err=%b exp 0 0 1 0 0",
                     rx_ready, ena, cpu_reset, done, error);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        load_nominal();
        send_frame(0);
        check_nominal_writes("after_reset");
    endtask

    task automatic test_reload();
        // Entered from DONE
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reload_status got cpu_rst=%b done=%b exp 1 0", cpu_reset, done);
        end
        clear_log();
        frame = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_frame(0);
        checks++;
        if (wr_addr.size() !== 1 || done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL reload_frame got writes=%0d done=%b cpu_rst=%b exp 1 1 0", wr_addr.size(), done, cpu_reset);
        end else begin
            checks++;
            if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'h00000013) begin
                failures++;
                $display("FAIL reload_write got addr=%0d data=%08h exp addr=0 data=00000013", wr_addr[0], wr_data[0]);
            end
        end
    endtask

    task automatic test_reload_ignored();
        do_reset();
        frame = '{8'h02};
        send_frame(0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        frame = '{8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
        clear_log();
        send_frame(0);
        checks++;
        if (done !== 1'b1 || wr_addr.size() !== 2) begin
            failures++;
            $display("FAIL reload_ignored got done=%b writes=%0d exp 1 2", done, wr_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reload();
        test_bad_csum();
        test_illegal_len();
        test_gaps();
        test_reset_midload();
        test_reload_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
